// File: rtl/jtkiwi_pcm_pkg.sv
// ============================================================================
// Module      : jtkiwi_pcm_pkg
// Description : Shared constants and voice state encoding for the PCM player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtkiwi_pcm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PTRL = 2'd1;
    localparam logic [1:0] ST_PTRH = 2'd2;
    localparam logic [1:0] ST_PLAY = 2'd3;

    localparam logic [7:0]  SILENCE  = 8'h80;
    localparam logic [7:0]  TERM     = 8'h00;
    localparam logic [15:0] ADDR_MAX = 16'hFFFF;

    // Unsigned sample to signed offset around the silence level.
    function automatic logic signed [8:0] centre(input logic [7:0] s);
        return $signed({1'b0, s}) - 9'sd128;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtkiwi_pcm_voice.sv
// ============================================================================
// Module      : jtkiwi_pcm_voice
// Description : One PCM voice: pointer lookup and byte streaming FSM.
//               Looping is built only with JTKIWI_PCM_LOOP_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkiwi_pcm_voice
    import jtkiwi_pcm_pkg::*;
#(
    parameter int          IDXW     = 6,
    parameter logic [15:0] TBL_BASE = 16'h90
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trig,
    input  logic [IDXW-1:0] idx,
    input  logic            loop,
    input  logic            fetch,
    input  logic [7:0]      data,
    output logic [15:0]     addr,
    output logic [7:0]      pcm_re,
    output logic            busy
);

    logic [1:0] state, state_nx;
    logic [7:0] lsb;
    logic       last;
    logic       rewind, stop;

`ifdef JTKIWI_PCM_LOOP_EN
    logic        loop_en;
    logic [15:0] start;
    assign rewind = (data == TERM) && loop_en;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign rewind      = 1'b0;
`endif

    // A byte fetched at ADDR_MAX is played; the following fetch ends the voice.
    assign stop = (data == TERM) ? !rewind : last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (trig) begin
            state_nx = ST_PTRL;
        end else if (fetch) begin
            case (state)
                ST_PTRL: state_nx = ST_PTRH;
                ST_PTRH: state_nx = ST_PLAY;
                ST_PLAY: if (stop) state_nx = ST_IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_comb busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= 16'd0;
            lsb    <= 8'd0;
            last   <= 1'b0;
            pcm_re <= SILENCE;
`ifdef JTKIWI_PCM_LOOP_EN
            loop_en <= 1'b0;
            start   <= 16'd0;
`endif
        end else if (trig) begin
            addr <= TBL_BASE + 16'({idx, 1'b0});
            last <= 1'b0;
`ifdef JTKIWI_PCM_LOOP_EN
            loop_en <= loop;
`endif
        end else if (fetch) begin
            case (state)
                ST_PTRL: begin
                    lsb     <= data;
                    addr[0] <= 1'b1;
                end
                ST_PTRH: begin
                    addr <= {data, lsb};
`ifdef JTKIWI_PCM_LOOP_EN
                    start <= {data, lsb};
`endif
                end
                ST_PLAY: begin
                    if (stop) begin
                        pcm_re <= SILENCE;
`ifdef JTKIWI_PCM_LOOP_EN
                    end else if (data == TERM) begin
                        addr <= start;
                        last <= 1'b0;
`endif
                    end else begin
                        pcm_re <= data;
                        if (addr == ADDR_MAX) last <= 1'b1;
                        else                  addr <= addr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtkiwi_pcmch.sv
// ============================================================================
// Module      : jtkiwi_pcmch
// Description : Multi-voice PCM sequencer: tick divider, shared ROM round
//               sequencer, overrun flag and voice mixer.
//               Optional looping: define JTKIWI_PCM_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkiwi_pcmch
    import jtkiwi_pcm_pkg::*;
#(
    parameter int          CH       = 2,
    parameter int          IDXW     = 6,
    parameter logic [15:0] TBL_BASE = 16'h90,
    parameter int          DIV      = 3
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample,
    input  logic [CH-1:0]              trig,
    input  logic [CH*IDXW-1:0]         idx,
    input  logic [CH-1:0]              loop,
    output logic [15:0]                rom_addr,
    output logic                       rom_cs,
    input  logic [7:0]                 rom_data,
    input  logic                       rom_ok,
    output logic                       pcm_cen,
    output logic [CH*8-1:0]            pcm_re,
    output logic signed [8+$clog2(CH):0] mix,
    output logic [CH-1:0]              busy,
    output logic                       overrun
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int MW = 9 + $clog2(CH);

    localparam logic [1:0] SQ_IDLE  = 2'd0;
    localparam logic [1:0] SQ_PICK  = 2'd1;
    localparam logic [1:0] SQ_FETCH = 2'd2;

    logic [1:0]    sq, sq_nx;
    logic          sample_l, sample_edge;
    logic [DW-1:0] div_cnt;
    logic [CH-1:0] trig_l, trig_ev, pending, live, fetch;
    logic [SW-1:0] cur, pick;
    logic [1:0]    age;
    logic          discard, accept, running;
    logic [15:0]   vaddr [CH];
    logic signed [MW-1:0] mix_nx;

    assign sample_edge = sample & ~sample_l;
    assign trig_ev     = trig & ~trig_l;
    // A voice retriggered this clk must not be picked with its stale address.
    assign live        = pending & ~trig_ev;
    assign running     = (sq == SQ_FETCH) || ((sq == SQ_PICK) && (|pending));

    always_comb begin
        pick = '0;
        for (int i = CH - 1; i >= 0; i--)
            if (live[i]) pick = SW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sq <= SQ_IDLE;
        else        sq <= sq_nx;
    end

    always_comb begin
        sq_nx = sq;
        case (sq)
            SQ_IDLE:  if (pcm_cen) sq_nx = SQ_PICK;
            SQ_PICK:  if (pcm_cen)    sq_nx = SQ_PICK;
                      else if (|live) sq_nx = SQ_FETCH;
                      else            sq_nx = SQ_IDLE;
            SQ_FETCH: if (pcm_cen || accept) sq_nx = SQ_PICK;
            default:  sq_nx = SQ_IDLE;
        endcase
    end

    // Data is accepted only once the address has been stable for two clks.
    always_comb begin
        rom_cs = (sq == SQ_FETCH);
        accept = (sq == SQ_FETCH) && rom_ok && (age == 2'd2);
        fetch  = '0;
        for (int i = 0; i < CH; i++)
            fetch[i] = accept && !discard && (cur == SW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l <= 1'b0;
            div_cnt  <= DW'(DIV - 1);
            pcm_cen  <= 1'b0;
            trig_l   <= '0;
            pending  <= '0;
            cur      <= '0;
            age      <= 2'd0;
            discard  <= 1'b0;
            rom_addr <= 16'd0;
            overrun  <= 1'b0;
        end else begin
            sample_l <= sample;
            trig_l   <= trig;
            pcm_cen  <= sample_edge && (div_cnt == '0);
            if (sample_edge)
                div_cnt <= (div_cnt == '0) ? DW'(DIV - 1) : div_cnt - 1'b1;

            if (pcm_cen) begin
                pending <= busy & ~trig_ev;
                if (running) overrun <= 1'b1;
            end else if ((sq == SQ_PICK) && (|live)) begin
                pending  <= live & ~(CH'(1) << pick);
                cur      <= pick;
                rom_addr <= vaddr[pick];
                age      <= 2'd1;
                discard  <= 1'b0;
            end else begin
                pending <= live;
            end

            if (sq == SQ_FETCH) begin
                if (age != 2'd2)  age <= age + 2'd1;
                if (trig_ev[cur]) discard <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < CH; g++) begin : g_voice
            jtkiwi_pcm_voice #(
                .IDXW     (IDXW),
                .TBL_BASE (TBL_BASE)
            ) u_voice (
                .clk    (clk),
                .rst_n  (rst_n),
                .trig   (trig_ev[g]),
                .idx    (idx[g*IDXW +: IDXW]),
                .loop   (loop[g]),
                .fetch  (fetch[g]),
                .data   (rom_data),
                .addr   (vaddr[g]),
                .pcm_re (pcm_re[g*8 +: 8]),
                .busy   (busy[g])
            );
        end
    endgenerate

    always_comb begin
        mix_nx = '0;
        for (int i = 0; i < CH; i++)
            mix_nx = mix_nx + MW'(centre(pcm_re[i*8 +: 8]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix <= '0;
        else        mix <= mix_nx;
    end

endmodule

`default_nettype wire
